irq_arbiter: RTL
================

# irq_arbiter

Arbitrates up to N external interrupt lines onto the single `ExtIRQ`/`ExtIAck` pair of the processor controller. Sequences one interrupt at a time through request, acknowledge and service, and blocks further requests until the handler returns via `ERet`. Sits between peripheral IRQ sources and the controller. It reports the winning source index so the exception handler can dispatch.

## Interface
- `N_IRQ`, default 4: number of IRQ lines, 2..16.
- `IW`, default `$clog2(N_IRQ)`: width of the source index.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `irq_req`  in  N_IRQ  level-sensitive requests; a source holds its line until acked.
- `ExtIAck`  in  1  controller acknowledge (`ExcAck & ExtIRQ`).
- `ERet`  in  1  controller decoded ERET; ends service.
- `Exc`  in  1  controller exception flag (internal exceptions, e.g. bad opcode).
- `ExtIRQ`  out  1  interrupt request to controller, registered.
- `irq_id`  out  IW  index of granted source; valid while `busy`.
- `irq_ack`  out  N_IRQ  one-hot, one-cycle acknowledge to the granted source.
- `busy`  out  1  high in REQ or SERVICE.
- `int_exc`  out  1  high while servicing an internal exception (no source granted).

## Operation
- States: IDLE, REQ, SERVICE. Reset → IDLE. `ExtIRQ`, `irq_id`, `irq_ack`, `busy`, `int_exc` = 0. Round-robin pointer = 0.
- IDLE:
  - If `Exc`=1 → SERVICE with `int_exc`=1. Any pending `irq_req` is ignored this cycle.
  - Else if `irq_req`≠0, select winner, latch `irq_id` → REQ.
  - Else stay.
- REQ:
  - `ExtIRQ`=1.
  - On `ExtIAck`=1: pulse `irq_ack[irq_id]` for that cycle → SERVICE.
  - `Exc` is ignored here: the controller echoes `Exc`=`ExtIRQ`.
  - If the granted `irq_req` bit drops before ack, stay in REQ anyway. The grant is not withdrawn.
- SERVICE:
  - `ExtIRQ`=0. Wait for `ERet`=1 → IDLE, clearing `int_exc`.
  - `irq_req` and `Exc` are ignored. No nesting.
- `ERet` in IDLE or REQ: ignored.
- `ExtIAck` outside REQ: ignored.
- Winner selection: fixed priority, lowest index wins, unless the round-robin option is enabled (see Configuration).
- `reset` in any state aborts immediately to the reset values. An in-flight `irq_ack` pulse is suppressed.

## Timing
- `irq_req` rising in IDLE at cycle t → `ExtIRQ`=1 from t+1.
- `ExtIAck` at cycle t in REQ → `irq_ack` high during cycle t+1 (registered) and `ExtIRQ`=0 from t+1.
- `ERet` at t in SERVICE → IDLE at t+1. A new `ExtIRQ` can assert at the earliest at t+2.
- `irq_id` stable from REQ entry until return to IDLE.
- Minimum IRQ-to-IRQ spacing: 4 cycles (IDLE, REQ, SERVICE, IDLE).

## Configuration
- `IRQ_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration starting at the pointer.
  - On each `irq_ack`, pointer ← (`irq_id`+1) mod `N_IRQ`.
  - Internal exceptions do not move the pointer.
- Undefined: fixed priority, lowest index wins. No pointer register.

## Structure
- Shared package `exc_pkg` holds:
  - state enum `irq_state_t` {IDLE, REQ, SERVICE};
  - EStatus codes `ESTAT_NONE`=4'b0000, `ESTAT_EXTIRQ`=4'b0001, `ESTAT_BADOP`=4'b0010.
- One sub-module, `irq_pick`: combinational winner selection from requests and pointer, outputs index and a valid flag. Both the fixed-priority and round-robin variants live inside it.

## Test plan
- Reset with `irq_req`=4'b1111 → all outputs 0 for every cycle that `reset` is held. First grant `irq_id`=0 in the cycle after release + 1.
- Single request:
  - `irq_req`=4'b0100 → `ExtIRQ` next cycle, `irq_id`=2.
  - `ExtIAck` → `irq_ack`=4'b0100 for exactly one cycle.
  - `ERet` → `busy`=0.
- Fixed priority: `irq_req`=4'b1010 held across two service loops → grants 1, 1. With `IRQ_ROUND_ROBIN_EN` → grants 1, 3.
- Simultaneous `Exc` and `irq_req`=4'b0001 in IDLE → SERVICE with `int_exc`=1 and `ExtIRQ` never asserted. After `ERet`, source 0 is granted.
- In SERVICE: new `irq_req`, `Exc` and stray `ExtIAck` → no `ExtIRQ`, no `irq_ack`. Spurious `ERet` in IDLE → no state change.
- `reset` asserted in REQ in the same cycle as `ExtIAck` → no `irq_ack` pulse. Outputs are 0 next cycle.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared exception/interrupt types: arbiter state encoding and EStatus cause codes.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [3:0] ESTAT_NONE   = 4'b0000;
  localparam logic [3:0] ESTAT_EXTIRQ = 4'b0001;
  localparam logic [3:0] ESTAT_BADOP  = 4'b0010;

endpackage

// File: rtl/irq_pick.sv
// Combinational winner selection over the IRQ request lines.
// With IRQ_ROUND_ROBIN_EN the search starts at ptr; otherwise the lowest index wins.
module irq_pick #(
  parameter int N_IRQ = 4,
  parameter int IW    = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
`ifdef IRQ_ROUND_ROBIN_EN
  input  logic [IW-1:0]    ptr,
`endif
  output logic [IW-1:0]    idx,
  output logic             valid
);

  // Scanning from the far end lets the highest-precedence line overwrite last.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    idx   = '0;
    valid = |req;
`ifdef IRQ_ROUND_ROBIN_EN
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N_IRQ]) begin
        idx = IW'((int'(ptr) + i) % N_IRQ);
      end
    end
`else
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
      end
    end
`endif
  end

endmodule

// File: rtl/irq_arbiter.sv
// Funnels N_IRQ level-sensitive interrupt lines onto the controller's single ExtIRQ/ExtIAck
// handshake, one at a time until ERET. Define IRQ_ROUND_ROBIN_EN for round-robin arbitration.
module irq_arbiter
  import exc_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int IW    = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic             ExtIAck,
  input  logic             ERet,
  input  logic             Exc,
  output logic             ExtIRQ,
  output logic [IW-1:0]    irq_id,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             busy,
  output logic             int_exc
);

  irq_state_t       state_q, state_d;
  logic             ext_irq_q, ext_irq_d;
  logic [IW-1:0]    irq_id_q, irq_id_d;
  logic [N_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic             int_exc_q, int_exc_d;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
`ifdef IRQ_ROUND_ROBIN_EN
  logic [IW-1:0]    ptr_q, ptr_d;
`endif

  irq_pick #(
    .N_IRQ (N_IRQ),
    .IW    (IW)
  ) u_pick (
    .req   (irq_req),
`ifdef IRQ_ROUND_ROBIN_EN
    .ptr   (ptr_q),
`endif
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    irq_ack_d = '0;
    int_exc_d = int_exc_q;
`ifdef IRQ_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        // An internal exception takes precedence; pending lines wait for the next IDLE.
        if (Exc) begin
          state_d   = SERVICE;
          int_exc_d = 1'b1;
        end else if (pick_valid) begin
          irq_id_d = pick_idx;
          state_d  = REQ;
        end
      end
      REQ: begin
        // The grant stands even if the source drops its line before the acknowledge.
        if (ExtIAck) begin
          irq_ack_d = N_IRQ'(1) << irq_id_q;
          state_d   = SERVICE;
`ifdef IRQ_ROUND_ROBIN_EN
          ptr_d     = (irq_id_q == IW'(N_IRQ - 1)) ? '0 : irq_id_q + IW'(1);
`endif
        end
      end
      SERVICE: begin
        if (ERet) begin
          state_d   = IDLE;
          int_exc_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    ext_irq_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      ext_irq_q <= 1'b0;
      irq_id_q  <= '0;
      irq_ack_q <= '0;
      int_exc_q <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ext_irq_q <= ext_irq_d;
      irq_id_q  <= irq_id_d;
      irq_ack_q <= irq_ack_d;
      int_exc_q <= int_exc_d;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign ExtIRQ  = ext_irq_q;
  assign irq_id  = irq_id_q;
  assign irq_ack = irq_ack_q;
  assign int_exc = int_exc_q;
  assign busy    = (state_q != IDLE);

endmodule
